// File: rtl/ticket_issuer.sv
// rtl/ticket_issuer.sv - debounced push-button ticket issuer feeding a customer queue

module ticket_issuer #(
    parameter int DT_SZ  = 4,
    parameter int DB_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic [DT_SZ-1:0] sw_time,
    input  logic             q_full,
    output logic             out_valid,
    output logic [DT_SZ-1:0] out_num,
    output logic [DT_SZ-1:0] out_time,
    output logic [DT_SZ-1:0] last_num,
    output logic [7:0]       issued_cnt,
    output logic             pending
);

    typedef enum logic [2:0] {IDLE, DBNC, ISSUE, HOLD, REL} state_t;

    localparam logic [7:0]       DB_LAST = 8'(DB_CYC - 1);
    localparam logic [DT_SZ-1:0] ONE     = DT_SZ'(1);

    state_t           state, state_nxt;
    logic [7:0]       db_cnt, db_cnt_nxt;
    logic             btn_m, btn_s;
    logic [DT_SZ-1:0] next_num;
    logic [DT_SZ-1:0] time_q;
    logic             issue;
    logic             latch_time;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
        end
    end

    // db_cnt counts stable-high cycles in DBNC and stable-low cycles in REL
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        issue      = 1'b0;
        latch_time = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt  = DBNC;
                    db_cnt_nxt = 8'd0;
                end
            end
            DBNC: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = ISSUE;
                    latch_time = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 8'd1;
                end
            end
            ISSUE: begin
                if (q_full) begin
                    state_nxt = HOLD;
                end else begin
                    issue      = 1'b1;
                    state_nxt  = REL;
                    db_cnt_nxt = 8'd0;
                end
            end
            HOLD: begin
                if (!q_full) begin
                    issue      = 1'b1;
                    state_nxt  = REL;
                    db_cnt_nxt = 8'd0;
                end
            end
            REL: begin
                if (btn_s) begin
                    db_cnt_nxt = 8'd0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    db_cnt_nxt = db_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            db_cnt     <= 8'd0;
            time_q     <= '0;
            out_valid  <= 1'b0;
            out_num    <= '0;
            out_time   <= '0;
            last_num   <= '0;
            issued_cnt <= 8'd0;
            pending    <= 1'b0;
            next_num   <= ONE;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            out_valid <= issue;
            pending   <= (state_nxt == HOLD);
            if (latch_time) begin
                time_q <= (sw_time == '0) ? ONE : sw_time;
            end
            if (issue) begin
                out_num  <= next_num;
                out_time <= time_q;
                last_num <= next_num;
                // zero is reserved to mean "nothing issued yet"
                next_num <= (next_num == '1) ? ONE : next_num + ONE;
                if (issued_cnt != 8'hFF) begin
                    issued_cnt <= issued_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ticket_issuer.sv
// tb/tb_ticket_issuer.sv - directed self-checking bench for ticket_issuer

module tb_ticket_issuer;

    localparam int DT_SZ  = 4;
    localparam int DB_CYC = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             btn;
    logic [DT_SZ-1:0] sw_time;
    logic             q_full;
    logic             out_valid;
    logic [DT_SZ-1:0] out_num;
    logic [DT_SZ-1:0] out_time;
    logic [DT_SZ-1:0] last_num;
    logic [7:0]       issued_cnt;
    logic             pending;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulse_cyc = -1;
    int consec  = 0;
    logic prev_valid = 1'b0;
    int pnum[$];
    int ptime[$];

    ticket_issuer #(.DT_SZ(DT_SZ), .DB_CYC(DB_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .sw_time    (sw_time),
        .q_full     (q_full),
        .out_valid  (out_valid),
        .out_num    (out_num),
        .out_time   (out_time),
        .last_num   (last_num),
        .issued_cnt (issued_cnt),
        .pending    (pending)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid) begin
            pnum.push_back(int'(out_num));
            ptime.push_back(int'(out_time));
            pulse_cyc = cyc;
            if (prev_valid) consec++;
        end
        prev_valid = out_valid;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        pnum.delete();
        ptime.delete();
        pulse_cyc = -1;
    endtask

    function automatic int first_num();
        return (pnum.size() > 0) ? pnum[0] : -1;
    endfunction

    function automatic int first_time();
        return (ptime.size() > 0) ? ptime[0] : -1;
    endfunction

    // clean press: hold high for hi cycles, then release long enough for REL to finish
    task automatic press(input int hi, input logic [DT_SZ-1:0] sw, output int e0);
        btn = 1'b1;
        sw_time = sw;
        tick();
        e0 = cyc;
        repeat (hi - 1) tick();
        btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  int'(out_valid), 0);
        check({tag, "_num"},    int'(out_num), 0);
        check({tag, "_time"},   int'(out_time), 0);
        check({tag, "_last"},   int'(last_num), 0);
        check({tag, "_cnt"},    int'(issued_cnt), 0);
        check({tag, "_pend"},   int'(pending), 0);
    endtask

    initial begin
        int e0;
        logic [4:0] bounce;
        rst_n = 1'b0;
        btn = 1'b0;
        sw_time = '0;
        q_full = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("rst");

        // clean 20-cycle press, sw_time=5
        clear_pulses();
        press(20, 4'd5, e0);
        check("clean_pulses", pnum.size(), 1);
        check("clean_latency", pulse_cyc - e0, DB_CYC + 3);
        check("clean_num", first_num(), 1);
        check("clean_time", first_time(), 5);
        check("clean_last", int'(last_num), 1);
        check("clean_cnt", int'(issued_cnt), 1);

        // bouncing press then stable high
        clear_pulses();
        bounce = 5'b01101;
        sw_time = 4'd7;
        for (int i = 0; i < 5; i++) begin
            btn = bounce[i];
            tick();
        end
        btn = 1'b1;
        tick();
        e0 = cyc;
        repeat (14) tick();
        btn = 1'b0;
        repeat (12) tick();
        check("bounce_pulses", pnum.size(), 1);
        check("bounce_latency", pulse_cyc - e0, DB_CYC + 3);
        check("bounce_num", first_num(), 2);
        check("bounce_time", first_time(), 7);

        // 16 presses from reset: numbers 1..15 then 1, sw_time=0 maps to 1
        do_reset();
        check_reset_outputs("rst2");
        for (int i = 0; i < 16; i++) begin
            clear_pulses();
            press(10, 4'(i), e0);
            check("wrap_pulses", pnum.size(), 1);
            check("wrap_num", first_num(), (i % 15) + 1);
            check("wrap_time", first_time(), (i == 0) ? 1 : i);
        end
        check("wrap_cnt", int'(issued_cnt), 16);
        check("wrap_last", int'(last_num), 1);

        // queue full across the issue point, sw_time changes while held
        clear_pulses();
        q_full = 1'b1;
        btn = 1'b1;
        sw_time = 4'd9;
        repeat (10) tick();
        check("hold_pend", int'(pending), 1);
        check("hold_nopulse", pnum.size(), 0);
        sw_time = 4'd3;
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        q_full = 1'b0;
        tick();
        check("hold_release_valid", int'(out_valid), 1);
        check("hold_release_pend", int'(pending), 0);
        repeat (12) tick();
        check("hold_pulses", pnum.size(), 1);
        check("hold_num", first_num(), 2);
        check("hold_time", first_time(), 9);
        check("hold_cnt", int'(issued_cnt), 17);
        check("hold_last", int'(last_num), 2);

        // reset while in HOLD discards the held ticket
        clear_pulses();
        q_full = 1'b1;
        btn = 1'b1;
        sw_time = 4'd6;
        repeat (10) tick();
        check("hrst_pend", int'(pending), 1);
        btn = 1'b0;
        do_reset();
        check_reset_outputs("hrst");
        q_full = 1'b0;
        repeat (12) tick();
        check("hrst_nopulse", pnum.size(), 0);
        press(10, 4'd4, e0);
        check("hrst_pulses", pnum.size(), 1);
        check("hrst_num", first_num(), 1);
        check("hrst_time", first_time(), 4);
        check("hrst_cnt", int'(issued_cnt), 1);

        check("no_consecutive_valid", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ticket_issuer.md
TICKET_ISSUER -- requirements
Module: ticket_issuer

Interface
REQ-001 Parameter DT_SZ, default 4: width of customer number and service time.
REQ-002 Parameter DB_CYC, default 16: consecutive stable cycles for a valid press or release (legal range 2..255).
REQ-003 Port clk  input  1: system clock, 20 ns period; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: synchronous, active-low reset.
REQ-005 Port btn  input  1: raw, asynchronous, bouncing ticket push-button, active-high.
REQ-006 Port sw_time  input  DT_SZ: requested service time from switches, quasi-static.
REQ-007 Port q_full  input  1: downstream queue full; an issue is not allowed while high.
REQ-008 Port out_valid  output  1: one-cycle ticket strobe that drives the queue write-valid input.
REQ-009 Port out_num  output  DT_SZ: customer number; valid while out_valid=1, holds its last value otherwise.
REQ-010 Port out_time  output  DT_SZ: service time; valid while out_valid=1, holds its last value otherwise.
REQ-011 Port last_num  output  DT_SZ: number of the most recently issued ticket, for display.
REQ-012 Port issued_cnt  output  8: total tickets issued, saturating.
REQ-013 Port pending  output  1: high while a ticket is held back by q_full.

Function
REQ-014 The block SHALL synchronise btn through two flip-flops; btn_s is the second-stage output, and all other logic SHALL use only btn_s.
REQ-015 The FSM SHALL have exactly five states: IDLE, DBNC, ISSUE, HOLD and REL.
REQ-016 IDLE: btn_s=1 -> DBNC with db_cnt cleared to 0; otherwise stay in IDLE.
REQ-017 DBNC: btn_s=0 -> IDLE; btn_s=1 and db_cnt=DB_CYC-1 -> ISSUE; otherwise increment db_cnt.
REQ-018 On entry to ISSUE, sw_time SHALL be latched; a value of 0 SHALL be replaced by 1, and values 1..15 pass unchanged.
REQ-019 ISSUE with q_full=0: assert out_valid for one cycle carrying {next_num, latched time}, then go to REL.
REQ-020 ISSUE with q_full=1: go to HOLD with pending=1 and out_valid=0.
REQ-021 HOLD: keep the latched ticket; on the first cycle q_full=0, issue it as in REQ-019, clear pending, then go to REL.
REQ-022 In HOLD, btn activity and sw_time changes SHALL be ignored.
REQ-023 REL: stay until btn_s=0 for DB_CYC consecutive cycles, then go to IDLE; any btn_s=1 restarts the count.
REQ-024 A held button SHALL yield exactly one ticket.
REQ-025 next_num SHALL start at 1 and advance on each issue; after 15 it SHALL wrap to 1, and 0 SHALL never be issued (0 means an empty counter).
REQ-026 Each issue SHALL set last_num to the issued number and increment issued_cnt, which saturates at 255.
REQ-027 Latency: with q_full=0 and btn stable high, out_valid SHALL be high on the edge DB_CYC+3 cycles after the first edge that samples btn=1.
REQ-028 out_valid SHALL never be high on two consecutive cycles, and SHALL never be high while q_full=1 is sampled in that cycle.
REQ-029 If q_full and the ISSUE decision occur in the same cycle, q_full takes priority and the state goes to HOLD.

Reset
REQ-030 rst_n=0 sampled on a clock edge SHALL force the following on the next edge:
- state=IDLE, db_cnt=0, synchroniser flops=0;
- out_valid=0, out_num=0, out_time=0, last_num=0;
- issued_cnt=0, pending=0, next_num=1.
REQ-031 Reset SHALL take effect in any state, including HOLD; a held ticket is discarded and not issued after reset.

Verification
REQ-032 DB_CYC=4, q_full=0, clean 20-cycle press with sw_time=5 -> one out_valid pulse at cycle 7 with num=1, time=5; last_num=1, issued_cnt=1.
REQ-033 Bouncing press (1,0,1,1,0 per cycle), then stable high -> exactly one ticket; no out_valid before btn has been stable high for DB_CYC cycles.
REQ-034 16 clean presses -> numbers 1..15 then 1; value 0 never appears; issued_cnt=16.
REQ-035 sw_time=0 on a press -> out_time=1.
REQ-036 q_full=1 held for 10 cycles across the issue point -> pending=1, no out_valid; q_full falls -> one pulse with the original time even if sw_time changed meanwhile, and pending=0.
REQ-037 rst_n=0 for one cycle while in HOLD -> all outputs reset, no pulse after q_full falls, and the next press issues num=1.
